// File: rtl/dds_rom_arbiter_if.sv
// Bus bundle for dds_rom_arbiter: channel config, per-channel request/grant,
// shared sine-ROM port and the channel-tagged sample return.
interface dds_rom_arbiter_if #(
   parameter int N_CH = 4
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic            cfg_we;
   logic [CW-1:0]   cfg_ch;
   logic [31:0]     cfg_fw;
   logic            cfg_clr;
`ifdef PHASE_OFFSET_EN
   logic            cfg_ofs_we;
   logic [7:0]      cfg_ofs;
`endif
   logic [N_CH-1:0] req_i;
   logic [N_CH-1:0] gnt_o;
   logic [7:0]      rom_addr_o;
   logic [7:0]      rom_q_i;
   logic [7:0]      sample_o;
   logic [CW-1:0]   sample_ch_o;
   logic            sample_v_o;

   modport slave (
      input  cfg_we, cfg_ch, cfg_fw, cfg_clr,
`ifdef PHASE_OFFSET_EN
      input  cfg_ofs_we, cfg_ofs,
`endif
      input  req_i, rom_q_i,
      output gnt_o, rom_addr_o, sample_o, sample_ch_o, sample_v_o
   );

   modport master (
      output cfg_we, cfg_ch, cfg_fw, cfg_clr,
`ifdef PHASE_OFFSET_EN
      output cfg_ofs_we, cfg_ofs,
`endif
      output req_i, rom_q_i,
      input  gnt_o, rom_addr_o, sample_o, sample_ch_o, sample_v_o
   );
endinterface

// File: rtl/dds_rom_arbiter.sv
// N_CH DDS phase accumulators sharing one 256x8 sine ROM through a round-robin arbiter.
// Optional per-channel 8-bit phase offset on the ROM address when PHASE_OFFSET_EN is defined.
module dds_rom_arbiter #(
   parameter int          N_CH   = 4,
   parameter logic [31:0] FW_RST = 32'd6710886
) (
   input logic              sclk,
   input logic              rst,
   dds_rom_arbiter_if.slave bus
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [31:0]     phase_q [N_CH];
   logic [31:0]     phase_d [N_CH];
   logic [31:0]     fw_q    [N_CH];
   logic [31:0]     fw_d    [N_CH];
`ifdef PHASE_OFFSET_EN
   logic [7:0]      ofs_q   [N_CH];
   logic [7:0]      ofs_d   [N_CH];
`endif
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [N_CH-1:0] gnt_q, gnt_d;
   logic [7:0]      addr_q, addr_d;
   logic            v1_q, v2_q;
   logic [CW-1:0]   ch1_q, ch2_q;
   logic [7:0]      sample_q;
   logic [CW-1:0]   sample_ch_q;
   logic            sample_v_q;

   logic [N_CH-1:0] elig_s;
   logic            win_v_s;
   logic [CW-1:0]   win_ch_s;
   logic            cfg_ok_s;

   // Round-robin pick; scanning from the far end lets the nearest eligible channel win last.
   always_comb begin
      elig_s   = bus.req_i & ~gnt_q;
      win_v_s  = 1'b0;
      win_ch_s = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         win_ch_s = elig_s[(int'(ptr_q) + i) % N_CH] ? CW'((int'(ptr_q) + i) % N_CH) : win_ch_s;
         win_v_s  = win_v_s | elig_s[(int'(ptr_q) + i) % N_CH];
      end
   end

   // Next state: lookup and accumulate for the winner, then config writes override.
   always_comb begin
      phase_d  = phase_q;
      fw_d     = fw_q;
      ptr_d    = ptr_q;
      gnt_d    = '0;
      addr_d   = addr_q;
      cfg_ok_s = (int'(bus.cfg_ch) < N_CH);
`ifdef PHASE_OFFSET_EN
      ofs_d    = ofs_q;
`endif
      if (win_v_s) begin
         gnt_d[win_ch_s]   = 1'b1;
         ptr_d             = (int'(win_ch_s) == N_CH - 1) ? '0 : win_ch_s + CW'(1);
`ifdef PHASE_OFFSET_EN
         addr_d            = phase_q[win_ch_s][31:24] + ofs_q[win_ch_s];
`else
         addr_d            = phase_q[win_ch_s][31:24];
`endif
         phase_d[win_ch_s] = phase_q[win_ch_s] + fw_q[win_ch_s];
      end else begin
         gnt_d = '0;
      end
      if (bus.cfg_we && cfg_ok_s) begin
         fw_d[bus.cfg_ch] = bus.cfg_fw;
         if (bus.cfg_clr) begin
            phase_d[bus.cfg_ch] = 32'd0;
         end else begin
            phase_d[bus.cfg_ch] = phase_d[bus.cfg_ch];
         end
      end else begin
         fw_d = fw_d;
      end
`ifdef PHASE_OFFSET_EN
      if (bus.cfg_ofs_we && cfg_ok_s) begin
         ofs_d[bus.cfg_ch] = bus.cfg_ofs;
      end else begin
         ofs_d = ofs_d;
      end
`endif
   end

   // State and output registers; the v1/v2 stages track the two-cycle ROM round trip.
   always_ff @(posedge sclk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            phase_q[i] <= 32'd0;
            fw_q[i]    <= FW_RST;
`ifdef PHASE_OFFSET_EN
            ofs_q[i]   <= 8'd0;
`endif
         end
         ptr_q       <= '0;
         gnt_q       <= '0;
         addr_q      <= 8'd0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         ch1_q       <= '0;
         ch2_q       <= '0;
         sample_q    <= 8'd0;
         sample_ch_q <= '0;
         sample_v_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         fw_q       <= fw_d;
`ifdef PHASE_OFFSET_EN
         ofs_q      <= ofs_d;
`endif
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         addr_q     <= addr_d;
         v1_q       <= win_v_s;
         ch1_q      <= win_ch_s;
         v2_q       <= v1_q;
         ch2_q      <= ch1_q;
         sample_v_q <= v2_q;
         if (v2_q) begin
            sample_q    <= bus.rom_q_i;
            sample_ch_q <= ch2_q;
         end
      end
   end

   assign bus.gnt_o       = gnt_q;
   assign bus.rom_addr_o  = addr_q;
   assign bus.sample_o    = sample_q;
   assign bus.sample_ch_o = sample_ch_q;
   assign bus.sample_v_o  = sample_v_q;
endmodule

// File: tb/tb_dds_rom_arbiter.sv
// Randomized and directed bench for dds_rom_arbiter against a transaction-level
// model (per-channel phase/fw arrays plus a queue of samples due at grant+2).
module tb_dds_rom_arbiter;
   localparam int          N_CH   = 4;
   localparam int          CW     = 2;
   localparam logic [31:0] FW_RST = 32'd6710886;

   logic sclk = 1'b0;
   logic rst;
   always #5 sclk = ~sclk;

   dds_rom_arbiter_if #(.N_CH(N_CH)) bus ();
   dds_rom_arbiter #(.N_CH(N_CH), .FW_RST(FW_RST)) dut (.sclk(sclk), .rst(rst), .bus(bus));

   // Shared ROM with a bijective fill so every address gives a distinct sample.
   function automatic logic [7:0] rom_fn(input logic [7:0] a);
      return a * 8'd37 + 8'd11;
   endfunction
   always @(posedge sclk) bus.rom_q_i <= rom_fn(bus.rom_addr_o);

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   typedef struct {int due; int ch; logic [7:0] val;} pend_t;
   pend_t       pend[$];
   logic [31:0] m_phase [N_CH];
   logic [31:0] m_fw    [N_CH];
   int          m_ptr, m_gnt, m_sch, cyc;
   logic [7:0]  m_addr, m_sample;
   logic        m_sv;
   logic [7:0]  aq[$];

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_phase[c] = 32'd0;
         m_fw[c]    = FW_RST;
      end
      m_ptr = 0; m_gnt = -1; m_addr = 8'd0; m_sample = 8'd0; m_sch = 0; m_sv = 1'b0;
      pend.delete();
   endtask

   // One edge of the reference: arbitration by rule, lookup, accumulate, config.
   task automatic model_step();
      int win;
      pend_t p;
      cyc++;
      if (rst) begin
         model_reset();
         return;
      end
      win = -1;
      for (int o = 0; o < N_CH; o++) begin
         int c;
         c = (m_ptr + o) % N_CH;
         if (win < 0 && bus.req_i[c] && c != m_gnt) win = c;
      end
      if (win >= 0) begin
         m_addr = m_phase[win][31:24];
         p.due = cyc + 2; p.ch = win; p.val = rom_fn(m_addr);
         pend.push_back(p);
         m_phase[win] = m_phase[win] + m_fw[win];
         m_ptr = (win + 1) % N_CH;
      end
      m_gnt = win;
      if (bus.cfg_we && int'(bus.cfg_ch) < N_CH) begin
         m_fw[bus.cfg_ch] = bus.cfg_fw;
         if (bus.cfg_clr) m_phase[bus.cfg_ch] = 32'd0;
      end
      m_sv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         p = pend.pop_front();
         m_sv = 1'b1; m_sample = p.val; m_sch = p.ch;
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      model_step();
      @(negedge sclk);
      check_eq("gnt",    32'(bus.gnt_o),       (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
      check_eq("addr",   32'(bus.rom_addr_o),  32'(m_addr));
      check_eq("sv",     32'(bus.sample_v_o),  32'(m_sv));
      check_eq("sample", 32'(bus.sample_o),    32'(m_sample));
      check_eq("sch",    32'(bus.sample_ch_o), 32'(m_sch));
   endtask

   task automatic cfg(input int ch, input logic [31:0] fw, input logic clr);
      bus.cfg_we = 1'b1; bus.cfg_ch = CW'(ch); bus.cfg_fw = fw; bus.cfg_clr = clr;
      tick();
      bus.cfg_we = 1'b0; bus.cfg_clr = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.req_i = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic collect(input int ch, input int n);
      aq.delete();
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.gnt_o[ch]) aq.push_back(bus.rom_addr_o);
      end
   endtask

   initial begin
      cyc = 0;
      model_reset();
      rst = 1'b1;
      bus.req_i = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_fw = 32'd0; bus.cfg_clr = 1'b0;
`ifdef PHASE_OFFSET_EN
      bus.cfg_ofs_we = 1'b0; bus.cfg_ofs = 8'd0;
`endif
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_gnt", 32'(bus.gnt_o), 32'd0);
      check_eq("rst_sv",  32'(bus.sample_v_o), 32'd0);

      // Single requester: grant every other cycle, addresses 0,0,0,1.
      bus.req_i = 4'b0001;
      collect(0, 8);
      check_eq("t1_cnt", 32'(aq.size()), 32'd4);
      if (aq.size() == 4) begin
         check_eq("t1_a0", 32'(aq[0]), 32'h00);
         check_eq("t1_a1", 32'(aq[1]), 32'h00);
         check_eq("t1_a2", 32'(aq[2]), 32'h00);
         check_eq("t1_a3", 32'(aq[3]), 32'h01);
      end

      // All requesting: one grant per cycle in rotation.
      bus.req_i = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_eq("t2_onehot", 32'($countones(bus.gnt_o)), 32'd1);
      end
      idle(3);

      // Channel 2 stepping one ROM entry per lookup.
      cfg(2, 32'h0100_0000, 1'b1);
      bus.req_i = 4'b0100;
      collect(2, 6);
      check_eq("t3_cnt", 32'(aq.size()), 32'd3);
      if (aq.size() == 3) begin
         check_eq("t3_a0", 32'(aq[0]), 32'h00);
         check_eq("t3_a1", 32'(aq[1]), 32'h01);
         check_eq("t3_a2", 32'(aq[2]), 32'h02);
      end
      idle(3);

      // Phase wrap on channel 1: 0x00, 0x80, then back to 0x00.
      cfg(1, 32'h8000_0000, 1'b1);
      bus.req_i = 4'b0010;
      collect(1, 6);
      check_eq("t4_cnt", 32'(aq.size()), 32'd3);
      if (aq.size() == 3) begin
         check_eq("t4_a1", 32'(aq[1]), 32'h80);
         check_eq("t4_a2", 32'(aq[2]), 32'h00);
      end
      idle(3);

      // Collision: clear channel 3 on the edge that grants it (phase 0x0600_0000).
      cfg(3, 32'h0300_0000, 1'b1);
      bus.req_i = 4'b1000;
      collect(3, 4);
      idle(3);
      bus.req_i = 4'b1000;
      bus.cfg_we = 1'b1; bus.cfg_ch = 2'd3; bus.cfg_fw = 32'h0100_0000; bus.cfg_clr = 1'b1;
      tick();
      bus.cfg_we = 1'b0; bus.cfg_clr = 1'b0;
      check_eq("t5_old_addr", 32'(bus.rom_addr_o), 32'h06);
      tick();
      tick();
      check_eq("t5_new_addr", 32'(bus.rom_addr_o), 32'h00);
      check_eq("t5_sv",       32'(bus.sample_v_o), 32'd1);
      check_eq("t5_sample",   32'(bus.sample_o),   32'(rom_fn(8'h06)));
      check_eq("t5_sch",      32'(bus.sample_ch_o), 32'd3);
      idle(3);

      // Reset one cycle after a grant discards the in-flight sample.
      bus.req_i = 4'b0001;
      tick();
      bus.req_i = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t6_sv",   32'(bus.sample_v_o),  32'd0);
         check_eq("t6_gnt",  32'(bus.gnt_o),       32'd0);
         check_eq("t6_addr", 32'(bus.rom_addr_o),  32'd0);
         check_eq("t6_smp",  32'(bus.sample_o),    32'd0);
         check_eq("t6_sch",  32'(bus.sample_ch_o), 32'd0);
      end

      // Random traffic with config writes (including fw=0) and rare resets.
      for (int i = 0; i < 600; i++) begin
         bus.req_i   = N_CH'($urandom);
         bus.cfg_we  = ($urandom_range(0, 7) == 0);
         bus.cfg_ch  = CW'($urandom);
         bus.cfg_fw  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
         bus.cfg_clr = 1'($urandom);
         rst         = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0; bus.cfg_we = 1'b0;
      idle(4);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/dds_rom_arbiter.md
Name: dds_rom_arbiter

Overview:
- Shares one 256x8 sine ROM (sp_ram_256x8, single-port, read-only, 1-cycle read latency, instantiated in the parent) between N_CH independent DDS channels.
- Each channel owns a 32-bit frequency word and a 32-bit phase accumulator. The phase advances only when the channel is granted a ROM lookup.
- A round-robin arbiter serves the per-channel sample requests and returns each sample tagged with its channel ID.
- Sits between the sample consumers (mixers/DAC formatters) and the shared sine table.

Parameters:
- N_CH, 4, number of channels (2..8); channel ID width CW = clog2(N_CH).
- FW_RST, 32'd6710886, frequency word loaded into every channel at reset.

Ports:
- sclk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CW  channel addressed by the config write.
- cfg_fw  in  32  new frequency word.
- cfg_clr  in  1  with cfg_we: also zero that channel's phase.
- req_i  in  N_CH  per-channel sample request (level).
- gnt_o  out  N_CH  one-hot grant pulse.
- rom_addr_o  out  8  address to the shared ROM.
- rom_q_i  in  8  ROM data, valid 1 cycle after the address.
- sample_o  out  8  returned sine sample.
- sample_ch_o  out  CW  channel ID of sample_o.
- sample_v_o  out  1  sample_o/sample_ch_o valid strobe.

Behaviour:
- Reset (rst high at an sclk edge):
  - gnt_o=0, rom_addr_o=0, sample_o=0, sample_ch_o=0, sample_v_o=0.
  - All phases=0, all frequency words=FW_RST, round-robin pointer=0.
  - Samples in flight are discarded; no sample_v_o appears after reset.
- Arbitration (every edge):
  - Eligible = req_i & ~gnt_o. A channel granted in cycle k cannot be granted in cycle k+1.
  - The first eligible channel at or after the pointer (wrapping modulo N_CH) wins.
  - gnt_o is registered, one-hot, and high for exactly one cycle. At most one grant per cycle.
  - If nothing is eligible, gnt_o=0.
- Pointer: after a grant to channel c, the pointer becomes (c+1) mod N_CH. It is unchanged when there is no grant.
- Lookup pipeline:
  - Cycle k (gnt_o[c]=1): rom_addr_o = phase[c][31:24], where phase[c] is the value before the update. At the same edge, phase[c] <= phase[c] + fw[c], modulo 2^32 (wrap silently).
  - Cycle k+1: rom_q_i carries the ROM data.
  - Cycle k+2: sample_o = rom_q_i as captured, sample_ch_o = c, sample_v_o = 1.
  - Latency from gnt_o to sample_v_o is fixed at 2 cycles. Fully pipelined: one sample per cycle sustained.
- Idle cycles: rom_addr_o holds its last value; sample_v_o=0; sample_o and sample_ch_o hold their last values.
- Requester rule: req_i is a level. A requester wanting a single sample drops req_i at the edge where it sees gnt_o.
- Config write:
  - cfg_we takes effect at the edge: fw[cfg_ch] <= cfg_fw.
  - If cfg_clr=1, phase[cfg_ch] <= 0.
  - Same-edge collision with a grant to cfg_ch:
    - The lookup uses the old phase.
    - The accumulation uses the old fw.
    - cfg_clr wins over the accumulation, so the phase ends at 0.
  - cfg_ch >= N_CH is ignored.
- fw=0: the channel returns a constant sample (its phase never moves).

Optional Feature:
- Macro PHASE_OFFSET_EN.
- Defined:
  - Adds ports cfg_ofs_we (in, 1) and cfg_ofs (in, 8), plus one 8-bit offset register per channel (reset 0).
  - cfg_ofs_we writes ofs[cfg_ch]; it may be asserted in the same cycle as cfg_we.
  - rom_addr_o = phase[c][31:24] + ofs[c], modulo 256.
  - Latency is unchanged.
- Undefined: no offset ports or registers; rom_addr_o = phase[c][31:24].

Test Plan:
- Reset, then req_i=4'b0001 held with fw[0]=FW_RST. Required:
  - gnt_o[0] in every other cycle.
  - rom_addr_o sequence 0x00, 0x00, 0x00, 0x01, ..., where 6710886 x 3 >> 24 = 1.
  - sample_v_o exactly 2 cycles after each grant, with sample_ch_o=0.
- req_i=4'b1111 held. Required:
  - Grants rotate 0, 1, 2, 3, 0, ... with one grant per cycle.
  - sample_ch_o sequence matches the grant order delayed by 2 cycles.
- cfg_we with cfg_ch=2, cfg_fw=32'h0100_0000, cfg_clr=1, then only ch2 requesting. Required: rom_addr_o = 0x00, 0x01, 0x02, ... on successive ch2 grants.
- Phase wrap: fw[1]=32'h8000_0000 with the phase at 32'h8000_0000. Required: the next grant's rom_addr_o=0x80, and the following grant's rom_addr_o=0x00.
- Collision: cfg_we (ch3, cfg_clr=1) on the same edge as gnt_o[3]. Required: that lookup returns the old-phase sample, and the next ch3 grant uses address 0x00.
- rst pulsed 1 cycle after a grant. Required: no sample_v_o afterwards, and all outputs equal their reset values.
